// File: rtl/decode_queue.sv
// Instruction decode queue: decodes RV32I/RV64I words on entry and buffers the
// decoded bundles in a DEPTH-entry FIFO between fetch and execute.
module decode_queue #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 2,
    parameter int ENABLE_M = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [6:0]                 out_opcode,
    output logic [4:0]                 out_rs,
    output logic [4:0]                 out_rs2,
    output logic [4:0]                 out_rd,
    output logic [2:0]                 out_funct3,
    output logic [6:0]                 out_funct7,
    output logic [5:0]                 out_shamt,
    output logic [XLEN-1:0]            out_imm,
    output logic [2:0]                 out_opcode_type,
    output logic                       out_is_load,
    output logic                       out_is_store,
    output logic                       out_is_writeback,
    output logic                       out_use_adder,
    output logic                       out_is_system,
    output logic                       out_is_mul,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] TYPE_R = 3'd0;
    localparam logic [2:0] TYPE_I = 3'd1;
    localparam logic [2:0] TYPE_S = 3'd2;
    localparam logic [2:0] TYPE_B = 3'd3;
    localparam logic [2:0] TYPE_U = 3'd4;
    localparam logic [2:0] TYPE_J = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rs;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [5:0]      shamt;
        logic [XLEN-1:0] imm;
        logic [2:0]      opcode_type;
        logic            is_load;
        logic            is_store;
        logic            is_writeback;
        logic            use_adder;
        logic            is_system;
        logic            is_mul;
        logic            illegal;
    } bundle_t;

    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    bundle_t         dec_p0;
    bundle_t         fifo_p1 [DEPTH];
    bundle_t         head_p1;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;

    // Stage 0: combinational decode of the incoming instruction
    always_comb begin
        dec_p0             = '0;
        dec_p0.pc          = in_pc;
        dec_p0.opcode      = in_inst[6:0];
        dec_p0.rs          = in_inst[19:15];
        dec_p0.rs2         = in_inst[24:20];
        dec_p0.rd          = in_inst[11:7];
        dec_p0.funct3      = in_inst[14:12];
        dec_p0.funct7      = in_inst[31:25];
        dec_p0.shamt       = (XLEN == 64) ? in_inst[25:20] : {1'b0, in_inst[24:20]};
        dec_p0.opcode_type = TYPE_I;
        dec_p0.illegal     = (in_inst[1:0] != 2'b11);
        case (in_inst[6:0])
            7'h37, 7'h17: begin
                dec_p0.is_writeback = 1'b1;
                dec_p0.opcode_type  = TYPE_U;
                dec_p0.imm          = sext32({in_inst[31:12], 12'b0});
            end
            7'h33: begin
                dec_p0.is_writeback = 1'b1;
                dec_p0.opcode_type  = TYPE_R;
                if (in_inst[31:25] == 7'h20) begin
                    if (in_inst[14:12] != 3'b000 && in_inst[14:12] != 3'b101)
                        dec_p0.illegal = 1'b1;
                end else if (in_inst[31:25] == 7'h01 && ENABLE_M != 0) begin
                    dec_p0.is_mul = 1'b1;
                end else if (in_inst[31:25] != 7'h00) begin
                    dec_p0.illegal = 1'b1;
                end
            end
            7'h13: begin
                dec_p0.is_writeback = 1'b1;
                dec_p0.imm          = sext32({{20{in_inst[31]}}, in_inst[31:20]});
            end
            7'h6F: begin
                dec_p0.is_writeback = 1'b1;
                dec_p0.use_adder    = 1'b1;
                dec_p0.opcode_type  = TYPE_J;
                dec_p0.imm          = sext32({{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                              in_inst[20], in_inst[30:21], 1'b0});
            end
            7'h67: begin
                dec_p0.is_writeback = 1'b1;
                dec_p0.use_adder    = 1'b1;
                dec_p0.imm          = sext32({{20{in_inst[31]}}, in_inst[31:20]});
            end
            7'h63: begin
                dec_p0.use_adder    = 1'b1;
                dec_p0.opcode_type  = TYPE_B;
                dec_p0.imm          = sext32({{19{in_inst[31]}}, in_inst[31], in_inst[7],
                                              in_inst[30:25], in_inst[11:8], 1'b0});
            end
            7'h03: begin
                dec_p0.is_load      = 1'b1;
                dec_p0.is_writeback = 1'b1;
                dec_p0.use_adder    = 1'b1;
                dec_p0.imm          = sext32({{20{in_inst[31]}}, in_inst[31:20]});
            end
            7'h23: begin
                dec_p0.is_store     = 1'b1;
                dec_p0.use_adder    = 1'b1;
                dec_p0.opcode_type  = TYPE_S;
                dec_p0.imm          = sext32({{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]});
            end
            7'h0F: begin
                dec_p0.imm          = sext32({{20{in_inst[31]}}, in_inst[31:20]});
            end
            7'h73: begin
                dec_p0.is_system    = 1'b1;
                dec_p0.imm          = sext32({{20{in_inst[31]}}, in_inst[31:20]});
            end
            default: dec_p0.illegal = 1'b1;
        endcase
        // Illegal words still flow in order, but must not trigger any side effect downstream
        if (dec_p0.illegal) begin
            dec_p0.is_load      = 1'b0;
            dec_p0.is_store     = 1'b0;
            dec_p0.is_writeback = 1'b0;
            dec_p0.use_adder    = 1'b0;
            dec_p0.is_mul       = 1'b0;
            dec_p0.imm          = '0;
        end
    end

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Stage 1: queue control and entry storage (storage is never reset)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_p1[wr_ptr] <= dec_p0;
    end

    assign head_p1          = fifo_p1[rd_ptr];
    assign out_pc           = head_p1.pc;
    assign out_opcode       = head_p1.opcode;
    assign out_rs           = head_p1.rs;
    assign out_rs2          = head_p1.rs2;
    assign out_rd           = head_p1.rd;
    assign out_funct3       = head_p1.funct3;
    assign out_funct7       = head_p1.funct7;
    assign out_shamt        = head_p1.shamt;
    assign out_imm          = head_p1.imm;
    assign out_opcode_type  = head_p1.opcode_type;
    assign out_is_load      = head_p1.is_load;
    assign out_is_store     = head_p1.is_store;
    assign out_is_writeback = head_p1.is_writeback;
    assign out_use_adder    = head_p1.use_adder;
    assign out_is_system    = head_p1.is_system;
    assign out_is_mul       = head_p1.is_mul;
    assign out_illegal      = head_p1.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue (XLEN=32, DEPTH=2, ENABLE_M=1): directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_decode_queue;

    localparam logic [2:0] TR = 3'd0, TI = 3'd1, TS = 3'd2, TB = 3'd3, TU = 3'd4, TJ = 3'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, out_imm;
    logic [6:0]  out_opcode, out_funct7;
    logic [4:0]  out_rs, out_rs2, out_rd;
    logic [2:0]  out_funct3, out_opcode_type;
    logic [5:0]  out_shamt;
    logic        out_is_load, out_is_store, out_is_writeback, out_use_adder;
    logic        out_is_system, out_is_mul, out_illegal;
    logic [1:0]  count;
    logic [5:0]  dut_flags;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic [5:0]  flags;   // {load, store, writeback, use_adder, mul, illegal}
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    assign dut_flags = {out_is_load, out_is_store, out_is_writeback, out_use_adder, out_is_mul, out_illegal};

    decode_queue #(.XLEN(32), .DEPTH(2), .ENABLE_M(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_shamt(out_shamt),
        .out_imm(out_imm), .out_opcode_type(out_opcode_type),
        .out_is_load(out_is_load), .out_is_store(out_is_store),
        .out_is_writeback(out_is_writeback), .out_use_adder(out_use_adder),
        .out_is_system(out_is_system), .out_is_mul(out_is_mul),
        .out_illegal(out_illegal), .count(count)
    );

    // Reference decode built from the class table and arithmetic immediate rules
    function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        int signed si;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic known, ld, st, wb, ad, ill, mul;
        si = $signed(inst);
        op = inst[6:0]; f7 = inst[31:25]; f3 = inst[14:12];
        e.pc = pc; e.rd = inst[11:7]; e.rs = inst[19:15];
        e.typ = TI; e.imm = '0;
        {ld, st, wb, ad} = 4'b0000;
        known = 1'b1;
        case (op)
            7'h37, 7'h17: begin wb = 1; e.typ = TU; e.imm = inst & 32'hFFFFF000; end
            7'h33: begin wb = 1; e.typ = TR; end
            7'h13: begin wb = 1; e.imm = si >>> 20; end
            7'h6F: begin wb = 1; ad = 1; e.typ = TJ;
                e.imm = (si >>> 31) * (1 << 20) + int'(inst[19:12]) * 4096
                        + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2; end
            7'h67: begin wb = 1; ad = 1; e.imm = si >>> 20; end
            7'h63: begin ad = 1; e.typ = TB;
                e.imm = (si >>> 31) * 4096 + int'(inst[7]) * 2048
                        + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2; end
            7'h03: begin ld = 1; wb = 1; ad = 1; e.imm = si >>> 20; end
            7'h23: begin st = 1; ad = 1; e.typ = TS; e.imm = (si >>> 25) * 32 + int'(inst[11:7]); end
            7'h0F, 7'h73: e.imm = si >>> 20;
            default: known = 1'b0;
        endcase
        ill = (inst[1:0] != 2'b11) || !known
              || (op == 7'h33 && !(f7 == 7'h00 || f7 == 7'h20 || f7 == 7'h01))
              || (op == 7'h33 && f7 == 7'h20 && !(f3 == 3'd0 || f3 == 3'd5));
        mul = (op == 7'h33) && (f7 == 7'h01) && !ill;
        if (ill) begin {ld, st, wb, ad} = 4'b0000; e.imm = '0; end
        e.flags = {ld, st, wb, ad, mul, ill};
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 11))
            0: r[6:0] = 7'h37;  1: r[6:0] = 7'h17;  2: r[6:0] = 7'h33;  3: r[6:0] = 7'h13;
            4: r[6:0] = 7'h6F;  5: r[6:0] = 7'h67;  6: r[6:0] = 7'h63;  7: r[6:0] = 7'h03;
            8: r[6:0] = 7'h23;  9: r[6:0] = 7'h0F;  10: r[6:0] = 7'h73;
            default: ;
        endcase
        if (r[6:0] == 7'h33) begin
            case ($urandom_range(0, 3))
                0: r[31:25] = 7'h00;
                1: r[31:25] = 7'h20;
                2: r[31:25] = 7'h01;
                default: ;
            endcase
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_chk++; if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1; in_inst = 32'h00500093; in_pc = 32'h0; out_ready = 1;
        tick();
        in_valid = 0;
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got=%b exp=1", out_valid); end
        n_chk++; if (out_rd !== 5'd1) begin n_fail++; $display("FAIL b2b_rd got=%0d exp=1", out_rd); end
        n_chk++; if (out_rs !== 5'd0) begin n_fail++; $display("FAIL b2b_rs got=%0d exp=0", out_rs); end
        n_chk++; if (out_rs2 !== 5'd5) begin n_fail++; $display("FAIL b2b_rs2 got=%0d exp=5", out_rs2); end
        n_chk++; if (out_shamt !== 6'd5) begin n_fail++; $display("FAIL b2b_shamt got=%0d exp=5", out_shamt); end
        n_chk++; if (out_opcode !== 7'h13) begin n_fail++; $display("FAIL b2b_opcode got=%h exp=13", out_opcode); end
        n_chk++; if ({out_funct3, out_funct7} !== 10'd0) begin n_fail++; $display("FAIL b2b_funct got=%h exp=0", {out_funct3, out_funct7}); end
        n_chk++; if (out_imm !== 32'd5) begin n_fail++; $display("FAIL b2b_imm got=%h exp=5", out_imm); end
        n_chk++; if (out_opcode_type !== TI) begin n_fail++; $display("FAIL b2b_type got=%0d exp=%0d", out_opcode_type, TI); end
        n_chk++; if (out_is_writeback !== 1'b1) begin n_fail++; $display("FAIL b2b_wb got=%b exp=1", out_is_writeback); end
        n_chk++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL b2b_illegal got=%b exp=0", out_illegal); end
        n_chk++; if (out_is_system !== 1'b0) begin n_fail++; $display("FAIL b2b_system got=%b exp=0", out_is_system); end
        n_chk++; if (count !== 2'd1) begin n_fail++; $display("FAIL b2b_count1 got=%0d exp=1", count); end
        tick();
        n_chk++; if (count !== 2'd0) begin n_fail++; $display("FAIL b2b_count0 got=%0d exp=0", count); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
        out_ready = 0;
    endtask

    task automatic test_imm_formats();
        logic [31:0] insts [3] = '{32'h12345137, 32'h0020A423, 32'hFE000EE3};
        logic [31:0] imms  [3] = '{32'h12345000, 32'h00000008, 32'hFFFFFFFC};
        logic [2:0]  types [3] = '{TU, TS, TB};
        logic        wbs   [3] = '{1'b1, 1'b0, 1'b0};
        logic        sts   [3] = '{1'b0, 1'b1, 1'b0};
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_inst = insts[i]; in_pc = 32'(32'h200 + 4 * i);
            tick();
            in_valid = 0;
            n_chk++; if (out_imm !== imms[i]) begin n_fail++; $display("FAIL imm_value[%0d] got=%h exp=%h", i, out_imm, imms[i]); end
            n_chk++; if (out_opcode_type !== types[i]) begin n_fail++; $display("FAIL imm_type[%0d] got=%0d exp=%0d", i, out_opcode_type, types[i]); end
            n_chk++; if (out_is_writeback !== wbs[i]) begin n_fail++; $display("FAIL imm_wb[%0d] got=%b exp=%b", i, out_is_writeback, wbs[i]); end
            n_chk++; if (out_is_store !== sts[i]) begin n_fail++; $display("FAIL imm_store[%0d] got=%b exp=%b", i, out_is_store, sts[i]); end
            if (i == 0) begin
                n_chk++; if (out_rd !== 5'd2) begin n_fail++; $display("FAIL imm_lui_rd got=%0d exp=2", out_rd); end
            end
            out_ready = 1;
            tick();
            out_ready = 0;
        end
    endtask

    task automatic test_backpressure();
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1; in_inst = 32'h00000013 | (32'(k + 1) << 7); in_pc = 32'(32'h100 + 4 * k);
            if (k == 2) begin
                n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
            end
            tick();
        end
        in_valid = 0;
        n_chk++; if (count !== 2'd2) begin n_fail++; $display("FAIL bp_count_full got=%0d exp=2", count); end
        n_chk++; if (out_pc !== 32'h100) begin n_fail++; $display("FAIL bp_head0 got=%h exp=100", out_pc); end
        tick();
        n_chk++; if (out_pc !== 32'h100) begin n_fail++; $display("FAIL bp_stable got=%h exp=100", out_pc); end
        out_ready = 1;
        tick();
        n_chk++; if (count !== 2'd1) begin n_fail++; $display("FAIL bp_count_after_pop got=%0d exp=1", count); end
        n_chk++; if (out_pc !== 32'h104) begin n_fail++; $display("FAIL bp_head1 got=%h exp=104", out_pc); end
        in_valid = 1; in_inst = 32'h00000013 | (32'd9 << 7); in_pc = 32'h10C;
        tick();
        in_valid = 0;
        n_chk++; if (count !== 2'd1) begin n_fail++; $display("FAIL bp_pushpop_count got=%0d exp=1", count); end
        n_chk++; if (out_pc !== 32'h10C) begin n_fail++; $display("FAIL bp_head2_pc got=%h exp=10c", out_pc); end
        n_chk++; if (out_rd !== 5'd9) begin n_fail++; $display("FAIL bp_head2_rd got=%0d exp=9", out_rd); end
        tick();
        n_chk++; if (count !== 2'd0) begin n_fail++; $display("FAIL bp_drained got=%0d exp=0", count); end
        out_ready = 0;
    endtask

    task automatic test_flush();
        out_ready = 0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1; in_inst = 32'h00100093; in_pc = 32'(32'h300 + 4 * k);
            tick();
        end
        in_pc = 32'h308; flush = 1;
        tick();
        flush = 0; in_valid = 0;
        n_chk++; if (count !== 2'd0) begin n_fail++; $display("FAIL flush_count got=%0d exp=0", count); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
        in_valid = 1; in_pc = 32'h400;
        tick();
        in_pc = 32'h404; flush = 1; out_ready = 1;
        tick();
        flush = 0; in_valid = 0;
        n_chk++; if (count !== 2'd0) begin n_fail++; $display("FAIL flush_drop_count got=%0d exp=0", count); end
        tick();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop_valid got=%b exp=0", out_valid); end
        out_ready = 0;
    endtask

    task automatic test_illegal();
        logic [31:0] insts [4] = '{32'h022081B3, 32'h00000000, 32'h4000F033, 32'h40005033};
        logic        muls  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic        ills  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic        wbs   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_inst = insts[i]; in_pc = 32'(32'h500 + 4 * i);
            tick();
            in_valid = 0;
            n_chk++; if (out_is_mul !== muls[i]) begin n_fail++; $display("FAIL ill_mul[%0d] got=%b exp=%b", i, out_is_mul, muls[i]); end
            n_chk++; if (out_illegal !== ills[i]) begin n_fail++; $display("FAIL ill_flag[%0d] got=%b exp=%b", i, out_illegal, ills[i]); end
            n_chk++; if (out_is_writeback !== wbs[i]) begin n_fail++; $display("FAIL ill_wb[%0d] got=%b exp=%b", i, out_is_writeback, wbs[i]); end
            n_chk++; if (out_imm !== 32'd0) begin n_fail++; $display("FAIL ill_imm[%0d] got=%h exp=0", i, out_imm); end
            out_ready = 1;
            tick();
            out_ready = 0;
        end
    endtask

    task automatic test_async_reset();
        out_ready = 0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1; in_inst = 32'h00200113; in_pc = 32'(32'h600 + 4 * k);
            tick();
        end
        in_valid = 0;
        n_chk++; if (count !== 2'd2) begin n_fail++; $display("FAIL areset_pre_count got=%0d exp=2", count); end
        out_ready = 1;
        #3 rst = 1;
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got=%b exp=0", out_valid); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_in_ready got=%b exp=1", in_ready); end
        n_chk++; if (count !== 2'd0) begin n_fail++; $display("FAIL areset_count got=%0d exp=0", count); end
        #1 rst = 0;
        tick();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_after got=%b exp=0", out_valid); end
        out_ready = 0;
    endtask

    task automatic test_random();
        int   sz;
        exp_t e;
        logic do_push, do_pop;
        q.delete();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = rand_inst();
            in_pc     = $urandom & 32'hFFFF_FFFC;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            sz = q.size();
            n_chk++; if (count !== 2'(sz)) begin n_fail++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, sz); end
            n_chk++; if (in_ready !== (sz != 2)) begin n_fail++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, sz != 2); end
            n_chk++; if (out_valid !== (sz != 0)) begin n_fail++; $display("FAIL rnd_out_valid c=%0d got=%b exp=%b", c, out_valid, sz != 0); end
            if (sz != 0) begin
                e = q[0];
                n_chk++; if (out_pc !== e.pc) begin n_fail++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, out_pc, e.pc); end
                n_chk++; if ({out_rd, out_rs} !== {e.rd, e.rs}) begin n_fail++; $display("FAIL rnd_regs c=%0d got=%h exp=%h", c, {out_rd, out_rs}, {e.rd, e.rs}); end
                n_chk++; if (out_imm !== e.imm) begin n_fail++; $display("FAIL rnd_imm c=%0d got=%h exp=%h", c, out_imm, e.imm); end
                n_chk++; if (dut_flags !== e.flags) begin n_fail++; $display("FAIL rnd_flags c=%0d got=%b exp=%b", c, dut_flags, e.flags); end
                if (!e.flags[0]) begin
                    n_chk++; if (out_opcode_type !== e.typ) begin n_fail++; $display("FAIL rnd_type c=%0d got=%0d exp=%0d", c, out_opcode_type, e.typ); end
                end
            end
            do_push = in_valid && (sz != 2) && !flush;
            do_pop  = out_ready && (sz != 0) && !flush;
            e = ref_decode(in_inst, in_pc);
            tick();
            if (flush) q.delete();
            else begin
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back(e);
            end
        end
        flush = 0; in_valid = 0; out_ready = 0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_imm_formats();
        test_backpressure();
        test_flush();
        test_illegal();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
